// File: rtl/image_layer_mixer.sv
// image_layer_mixer
//   NUM_IMG writable image memories; image 0 is the background layer. A
//   per-frame overlay image is composited over the background using a
//   transparent colour key, through a 3-stage registered read pipeline.
//
// Ports
//   IN_CLK, IN_RST_N        clock, async active-low reset
//   IN_REQ, IN_ADDR         read request / pixel address
//   IN_FRAME_START          frame pulse; IN_SELECTOR sampled here
//   IN_SELECTOR             requested overlay image
//   IN_WE, IN_WSEL,
//   IN_WADDR, IN_WDATA      single-cycle image write
//   OUT_VALID, OUT_RGB      composited pixel (RGB holds when not valid)
//   OUT_OOR                 output came from an out-of-range address
//   OUT_ACTIVE_SEL          overlay selector in effect
//   OUT_SEL_ERR             sticky: invalid selector was sampled
module image_layer_mixer #(
  parameter int                ADDR_W  = 16,
  parameter int                DEPTH   = 19200,
  parameter int                PIX_W   = 48,
  parameter int                NUM_IMG = 8,
  parameter int                SEL_W   = 3,
  parameter logic [PIX_W-1:0]  KEY     = '0
) (
  input  logic              IN_CLK,
  input  logic              IN_RST_N,
  input  logic              IN_REQ,
  input  logic [ADDR_W-1:0] IN_ADDR,
  input  logic              IN_FRAME_START,
  input  logic [SEL_W-1:0]  IN_SELECTOR,
  input  logic              IN_WE,
  input  logic [SEL_W-1:0]  IN_WSEL,
  input  logic [ADDR_W-1:0] IN_WADDR,
  input  logic [PIX_W-1:0]  IN_WDATA,
  output logic              OUT_VALID,
  output logic [PIX_W-1:0]  OUT_RGB,
  output logic              OUT_OOR,
  output logic [SEL_W-1:0]  OUT_ACTIVE_SEL,
  output logic              OUT_SEL_ERR
);

  localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              STAGES    = 3;
  localparam logic [SEL_W:0]  NUM_IMG_W = (SEL_W+1)'(NUM_IMG);
  localparam logic [ADDR_W:0] DEPTH_W   = (ADDR_W+1)'(DEPTH);

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [AW-1:0]    addr;
    logic [PIX_W-1:0] data;
  } wr_req_t;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [AW-1:0]    addr;
    logic             oor;
  } rd_req_t;

  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              sel_err_q, sel_err_d;
  logic [STAGES:1]   vld_pipe_q;
  rd_req_t           s1_q, s1_d;
  logic [SEL_W-1:0]  s2_sel_q;
  logic              s2_oor_q;
  logic              we_q, we_d;
  wr_req_t           wr_q, wr_d;
  logic [PIX_W-1:0]  rgb_q, rgb_d;
  logic              oor_q;
  logic [PIX_W-1:0]  ov;

  logic [NUM_IMG-1:0][PIX_W-1:0] rd_data;

  // Selector: sampled only on frame start, invalid values clamp to the
  // background and latch the sticky error. A request in the frame-start
  // cycle picks up the freshly sampled value through sel_d.
  always_comb begin
    sel_d     = sel_q;
    sel_err_d = sel_err_q;
    if (IN_FRAME_START) begin
      if ({1'b0, IN_SELECTOR} >= NUM_IMG_W) begin
        sel_d     = '0;
        sel_err_d = 1'b1;
      end else begin
        sel_d     = IN_SELECTOR;
      end
    end
  end

  always_comb begin
    s1_d      = '0;
    s1_d.sel  = sel_d;
    s1_d.addr = IN_ADDR[AW-1:0];
    s1_d.oor  = ({1'b0, IN_ADDR} >= DEPTH_W);
  end

  // Writes are registered one cycle before reaching the RAMs. The RAM read
  // for a request happens one edge after it is sampled, so delaying the
  // write keeps a same-cycle read seeing old data (read-first) while reads
  // issued the next cycle see the new data.
  always_comb begin
    we_d      = IN_WE && ({1'b0, IN_WSEL} < NUM_IMG_W) &&
                ({1'b0, IN_WADDR} < DEPTH_W);
    wr_d      = '0;
    wr_d.sel  = IN_WSEL;
    wr_d.addr = IN_WADDR[AW-1:0];
    wr_d.data = IN_WDATA;
  end

  // Image 0's single read port serves as the background for every pixel;
  // when sel==0 the overlay is never used, so no second port is needed.
  always_comb begin
    ov = rd_data[0];
    for (int g = 1; g < NUM_IMG; g++)
      if (s2_sel_q == SEL_W'(g)) ov = rd_data[g];
  end

  always_comb begin
    rgb_d = rd_data[0];
    if (s2_oor_q)                          rgb_d = '0;
    else if (s2_sel_q != '0 && ov != KEY)  rgb_d = ov;
  end

  always_ff @(posedge IN_CLK or negedge IN_RST_N) begin
    if (!IN_RST_N) begin
      sel_q      <= '0;
      sel_err_q  <= 1'b0;
      vld_pipe_q <= '0;
      s1_q       <= '0;
      s2_sel_q   <= '0;
      s2_oor_q   <= 1'b0;
      we_q       <= 1'b0;
      wr_q       <= '0;
      rgb_q      <= '0;
      oor_q      <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      sel_err_q  <= sel_err_d;
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], IN_REQ};
      s1_q       <= s1_d;
      s2_sel_q   <= s1_q.sel;
      s2_oor_q   <= s1_q.oor;
      we_q       <= we_d;
      wr_q       <= wr_d;
      if (vld_pipe_q[2]) begin
        rgb_q <= rgb_d;
        oor_q <= s2_oor_q;
      end
    end
  end

  for (genvar g = 0; g < NUM_IMG; g++) begin : g_img
    image_layer_mixer_ram #(
      .AW    (AW),
      .DEPTH (DEPTH),
      .PIX_W (PIX_W)
    ) u_ram (
      .clk_i   (IN_CLK),
      .we_i    (we_q && (wr_q.sel == SEL_W'(g))),
      .waddr_i (wr_q.addr),
      .wdata_i (wr_q.data),
      .raddr_i (s1_q.addr),
      .rdata_o (rd_data[g])
    );
  end

  assign OUT_VALID      = vld_pipe_q[STAGES];
  assign OUT_RGB        = rgb_q;
  assign OUT_OOR        = oor_q;
  assign OUT_ACTIVE_SEL = sel_q;
  assign OUT_SEL_ERR    = sel_err_q;

endmodule

// image_layer_mixer_ram
//   Simple dual-port image RAM, read-first, registered read data, no reset
//   so it maps onto block RAM. Contents survive the design reset.
//   clk_i; we_i/waddr_i/wdata_i write port; raddr_i/rdata_o read port.
module image_layer_mixer_ram #(
  parameter int AW    = 15,
  parameter int DEPTH = 19200,
  parameter int PIX_W = 48
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [PIX_W-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [PIX_W-1:0] rdata_o
);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [PIX_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule
